// File: rtl/led_fader_if.sv
// Signal bundle between the LED counter side and the fader output stage.
// The master drives the enable and the counter value; the slave (the fader)
// returns the pin drive and the busy flag.
interface led_fader_if #(
    parameter int N_CH = 4
);
    logic            en;
    logic [N_CH-1:0] value;
    logic [N_CH-1:0] led;
    logic            busy;

    modport master (
        output en,
        output value,
        input  led,
        input  busy
    );

    modport slave (
        input  en,
        input  value,
        output led,
        output busy
    );
endinterface

// File: rtl/led_fader.sv
// led_fader: turns each bit of the asynchronous LED counter value into a PWM
// channel whose brightness ramps one step per prescaler tick towards full-on
// or full-off. Brightness is linear by default; defining LED_FADER_GAMMA_EN
// adds a registered square-law duty mapping (one extra cycle to the pin).
module led_fader #(
    parameter int N_CH     = 4,
    parameter int FADE_DIV = 15625,
    parameter int PWM_BITS = 8
) (
    input  logic        clk,
    input  logic        rst,
    led_fader_if.slave  bus
);

    localparam int PRESC_W = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
    localparam logic [PRESC_W-1:0]  PRESC_LAST = PRESC_W'(FADE_DIV - 1);
    localparam logic [PWM_BITS-1:0] LEVEL_MAX  = '1;

    logic [N_CH-1:0]     sync1_reg;
    logic [N_CH-1:0]     sync2_reg;
    logic [PRESC_W-1:0]  presc_reg;
    logic [PWM_BITS-1:0] pwm_cnt_reg;
    logic                tick;
    logic [N_CH-1:0]     led_bits;
    logic [N_CH-1:0]     diff_bits;
    logic                busy_reg;

    // Two-flop synchroniser for the counter value coming from the divided clock.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= bus.value;
            sync2_reg <= sync1_reg;
        end
    end

    // Fade-rate prescaler; frozen (and ticking never) while en is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_reg <= '0;
        end else if (bus.en) begin
            presc_reg <= tick ? '0 : presc_reg + 1'b1;
        end
    end

    assign tick = bus.en && (presc_reg == PRESC_LAST);

    // Free-running PWM period counter, independent of en.
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_cnt_reg <= '0;
        end else begin
            pwm_cnt_reg <= pwm_cnt_reg + 1'b1;
        end
    end

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
            logic [PWM_BITS-1:0] target;
            logic [PWM_BITS-1:0] bright_reg;
            logic [PWM_BITS-1:0] duty;
            logic                led_reg;

            assign target = sync2_reg[gi] ? LEVEL_MAX : '0;

            // Step brightness by one towards the target on each tick; a target
            // change seen in the tick cycle only takes effect on the next tick.
            always_ff @(posedge clk) begin
                if (rst) begin
                    bright_reg <= '0;
                end else if (tick) begin
                    if (bright_reg < target) begin
                        bright_reg <= bright_reg + 1'b1;
                    end else if (bright_reg > target) begin
                        bright_reg <= bright_reg - 1'b1;
                    end
                end
            end

`ifdef LED_FADER_GAMMA_EN
            logic [2*PWM_BITS-1:0] square;
            logic [PWM_BITS-1:0]   duty_reg;

            assign square = {{PWM_BITS{1'b0}}, bright_reg} * {{PWM_BITS{1'b0}}, bright_reg};

            // Square-law duty; the top level is forced to full-on so a finished
            // up-ramp still gives a steady pin.
            always_ff @(posedge clk) begin
                if (rst) begin
                    duty_reg <= '0;
                end else if (bright_reg == LEVEL_MAX) begin
                    duty_reg <= LEVEL_MAX;
                end else begin
                    duty_reg <= square[2*PWM_BITS-1:PWM_BITS];
                end
            end

            assign duty = duty_reg;
`else
            assign duty = bright_reg;
`endif

            // Registered PWM compare; full duty is a constant high.
            always_ff @(posedge clk) begin
                if (rst) begin
                    led_reg <= 1'b0;
                end else begin
                    led_reg <= (duty == LEVEL_MAX) || (duty > pwm_cnt_reg);
                end
            end

            assign led_bits[gi]  = led_reg;
            assign diff_bits[gi] = (bright_reg != target);
        end
    endgenerate

    // Busy flag reflects the previous edge's brightness/target mismatch.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_reg <= 1'b0;
        end else begin
            busy_reg <= |diff_bits;
        end
    end

    assign bus.led  = led_bits;
    assign bus.busy = busy_reg;

endmodule

// File: tb/tb_led_fader.sv
// Testbench for led_fader: directed phases from the test plan followed by
// randomized value/en/rst segments, all checked every cycle against a
// cycle-count based reference model of the fader behaviour.
module tb_led_fader;

    localparam int N_CH = 4;
    localparam int DIV  = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    led_fader_if #(.N_CH(N_CH)) bus ();

    led_fader #(
        .N_CH     (N_CH),
        .FADE_DIV (DIV),
        .PWM_BITS (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: brightness per channel, duty seen by the pin
    // (gamma only), value samples of the last two edges, edge counters.
    int m_bright [N_CH];
    int m_duty   [N_CH];
    int vhist    [$];
    int m_cyc;
    int m_en_cnt;
    int m_led;
    int m_busy;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int gamma_of(input int b);
        if (b == 255) return 255;
        return (b * b) / 256;
    endfunction

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_edge();
        int tgt;
        int pwm;
        int src;
        bit tick;
        int nled;
        int nbusy;
        if (rst) begin
            foreach (m_bright[i]) begin
                m_bright[i] = 0;
                m_duty[i]   = 0;
            end
            vhist    = '{0, 0};
            m_cyc    = 0;
            m_en_cnt = 0;
            m_led    = 0;
            m_busy   = 0;
            return;
        end
        pwm   = m_cyc % 256;
        tick  = bus.en && ((m_en_cnt % DIV) == DIV - 1);
        nled  = 0;
        nbusy = 0;
        for (int i = 0; i < N_CH; i++) begin
            // target seen now is the value sampled two edges ago
            tgt = ((vhist[0] >> i) & 1) ? 255 : 0;
`ifdef LED_FADER_GAMMA_EN
            src = m_duty[i];
            m_duty[i] = gamma_of(m_bright[i]);
`else
            src = m_bright[i];
`endif
            if (src == 255 || src > pwm) nled |= (1 << i);
            if (m_bright[i] != tgt) nbusy = 1;
            if (tick) begin
                if (m_bright[i] < tgt) m_bright[i]++;
                else if (m_bright[i] > tgt) m_bright[i]--;
            end
        end
        m_led  = nled;
        m_busy = nbusy;
        void'(vhist.pop_front());
        vhist.push_back(int'(bus.value));
        m_cyc++;
        m_en_cnt += bus.en ? 1 : 0;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("led", bus.led, m_led);
        check("busy", bus.busy, m_busy);
    endtask

    task automatic run_until_bright(input string tag, input int ch, input int lvl, input int budget);
        int n = 0;
        while (m_bright[ch] != lvl && n < budget) begin
            step();
            n++;
        end
        check(tag, m_bright[ch], lvl);
    endtask

    task automatic run_until_idle(input int budget);
        int n = 0;
        while ((m_busy != 0 || bus.busy !== 1'b0 || n < 4) && n < budget) begin
            step();
            n++;
        end
        check("idle_timeout", bus.busy, 0);
    endtask

    task automatic count_highs(input int ch, output int cnt);
        cnt = 0;
        for (int k = 0; k < 256; k++) begin
            step();
            if (bus.led[ch] === 1'b1) cnt++;
        end
    endtask

    localparam int RAMP = 254 * DIV + DIV + 2 + 16;

    initial begin
        int cnt;
        int n;
`ifdef LED_FADER_GAMMA_EN
        int lvl_quarter = 128;
        int exp_15      = 0;
`else
        int lvl_quarter = 64;
        int exp_15      = 15;
`endif
        rst       = 1'b1;
        bus.en    = 1'b1;
        bus.value = 4'hF;
        vhist     = '{0, 0};

        // Reset with value = F held: outputs stay low.
        for (int k = 0; k < 3; k++) step();
        rst       = 1'b0;
        bus.value = '0;
        step();
        check("rst_release_led", bus.led, 0);
        check("rst_release_busy", bus.busy, 0);
        $display("reset phase done");

        // Fade up channel 0.
        bus.value = 4'b0001;
        step();
        step();
        check("busy_pre", bus.busy, 0);
        step();
        check("busy_rise", bus.busy, 1);
        n = 3;
        while (m_bright[0] != 255 && n < RAMP) begin
            step();
            n++;
        end
        check("ramp_reached", m_bright[0], 255);
        check("ramp_len_ok", (n <= 2 + DIV + 254 * DIV + 1), 1);
        for (int k = 0; k < 4; k++) step();
        check("full_busy", bus.busy, 0);
        count_highs(0, cnt);
        check("full_ch0_highs", cnt, 256);
        count_highs(3, cnt);
        check("full_ch3_highs", cnt, 0);
        $display("fade up done in %0d cycles", n);

        // Duty accuracy: stop at the level that gives 64/256.
        bus.value = '0;
        run_until_idle(RAMP);
        bus.value = 4'b0001;
        run_until_bright("reach_quarter", 0, lvl_quarter, RAMP);
        bus.en = 1'b0;
        for (int k = 0; k < 4; k++) step();
        for (int p = 0; p < 4; p++) begin
            count_highs(0, cnt);
            check("duty64_highs", cnt, 64);
        end
        $display("duty accuracy done");

        // Low level: 15 (gamma maps it to 0).
        bus.en    = 1'b1;
        bus.value = '0;
        run_until_bright("reach_15", 0, 15, RAMP);
        bus.en = 1'b0;
        for (int k = 0; k < 4; k++) step();
        count_highs(0, cnt);
        check("level15_highs", cnt, exp_15);
        bus.en = 1'b1;
        $display("low level done");

        // Reversal at 100.
        run_until_idle(RAMP);
        bus.value = 4'b0001;
        run_until_bright("reach_100", 0, 100, RAMP);
        bus.value = '0;
        run_until_bright("reverse_to_0", 0, 0, RAMP);
        for (int k = 0; k < 4; k++) step();
        count_highs(0, cnt);
        check("rev_end_highs", cnt, 0);
        $display("reversal done");

        // Reset mid-ramp at 150.
        bus.value = 4'b0001;
        run_until_bright("reach_150", 0, 150, RAMP);
        rst = 1'b1;
        step();
        check("midrst_led", bus.led, 0);
        check("midrst_busy", bus.busy, 0);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) step();
        check("restart_busy", bus.busy, 1);
        run_until_bright("restart_ramp", 0, 20, RAMP);
        $display("reset mid-ramp done");

        // Randomized segments.
        for (int s = 0; s < 24; s++) begin
            bus.value = 4'($urandom);
            bus.en    = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 9) == 0);
            n         = $urandom_range(1, 700);
            if (rst) begin
                step();
                rst = 1'b0;
            end
            for (int k = 0; k < n; k++) step();
            $display("segment %0d value=%h en=%0d cycles=%0d", s, bus.value, bus.en, n);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
